// File: rtl/angle_bin2ascii_if.sv
// angle_bin2ascii_if
// Handshake bundle between the angle producer and the binary-to-ASCII converter.
//   in_valid  : single-cycle strobe qualifying in_value (master -> slave)
//   in_value  : unsigned binary value, WIDTH bits (master -> slave)
//   busy      : conversion in progress (slave -> master)
//   out_valid : one-cycle pulse, ascii_out updated (slave -> master)
//   ascii_out : DIGITS ASCII characters, MSD in the top byte (slave -> master)
interface angle_bin2ascii_if #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_value;
  logic                  busy;
  logic                  out_valid;
  logic [8*DIGITS-1:0]   ascii_out;

  modport master (
    output in_valid, in_value,
    input  busy, out_valid, ascii_out
  );

  modport slave (
    input  in_valid, in_value,
    output busy, out_valid, ascii_out
  );
endinterface

// File: rtl/angle_bin2ascii.sv
// angle_bin2ascii
// Sequential binary-to-ASCII decimal converter (shift-add-3, one bit per clock)
// feeding LCD character fields such as the "SA:" set-angle display.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : angle_bin2ascii_if slave (in_valid, in_value, busy, out_valid, ascii_out)
// An update arriving mid-conversion is parked in a one-deep pending slot
// (latest wins) and converted right after the current result is published.
module angle_bin2ascii #(
  parameter int          WIDTH         = 13,
  parameter int          DIGITS        = 4,
  parameter int          BLANK_LEADING = 1,
  parameter logic [7:0]  BLANK_CHAR    = 8'h20,
  parameter int          SKIP_SAME     = 1
) (
  input  logic           clk,
  input  logic           rst,
  angle_bin2ascii_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [8*DIGITS-1:0] RESET_ASCII = {{(DIGITS-1){BLANK_CHAR}}, 8'h30};

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t              state;
  logic [WIDTH-1:0]    bin_sr;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    conv_value;
  logic [WIDTH-1:0]    last_value;
  logic                last_valid;
  logic [WIDTH-1:0]    pend_value;
  logic                pend_valid;
  logic                busy;
  logic                out_valid;
  logic [8*DIGITS-1:0] ascii;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_next;
  logic [WIDTH-1:0]    bin_next;
  logic [8*DIGITS-1:0] ascii_fmt;
  logic                leading;
  logic                do_load;
  logic [WIDTH-1:0]    load_value;

  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.ascii_out = ascii;

  // Double-dabble step: correct nibbles >= 5 so the following shift carries
  // into the next decimal digit.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  assign bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign bin_next = {bin_sr[WIDTH-2:0], 1'b0};

  // Digit-to-character mapping; leading zeros above the ones digit are
  // blanked until the first nonzero digit is seen, internal zeros stay.
  always_comb begin
    ascii_fmt = '0;
    leading   = (BLANK_LEADING != 0);
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (leading && (d != 0) && (bcd[4*d +: 4] == 4'd0)) begin
        ascii_fmt[8*d +: 8] = BLANK_CHAR;
      end else begin
        leading             = 1'b0;
        ascii_fmt[8*d +: 8] = {4'h3, bcd[4*d +: 4]};
      end
    end
  end

  // Load selection: a fresh strobe beats the pending slot when leaving
  // FORMAT, and a value equal to the one just shown is dropped when
  // SKIP_SAME is set.
  always_comb begin
    do_load    = 1'b0;
    load_value = bus.in_value;
    case (state)
      IDLE: begin
        do_load = bus.in_valid &&
                  !((SKIP_SAME != 0) && last_valid && (bus.in_value == last_value));
      end
      FORMAT: begin
        if (bus.in_valid) begin
          do_load = !((SKIP_SAME != 0) && (bus.in_value == conv_value));
        end else if (pend_valid) begin
          load_value = pend_value;
          do_load    = !((SKIP_SAME != 0) && (pend_value == conv_value));
        end
      end
      default: ;
    endcase
  end

  // Converter FSM; out_valid is a one-cycle pulse, and a load issued from
  // FORMAT overrides the default return to IDLE so busy never drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd        <= '0;
      cnt        <= '0;
      conv_value <= '0;
      last_value <= '0;
      last_valid <= 1'b0;
      pend_value <= '0;
      pend_valid <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      ascii      <= RESET_ASCII;
    end else begin
      out_valid <= 1'b0;
      case (state)
        SHIFT: begin
          if (bus.in_valid) begin
            pend_valid <= 1'b1;
            pend_value <= bus.in_value;
          end
          bcd    <= bcd_next;
          bin_sr <= bin_next;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FORMAT;
        end
        FORMAT: begin
          ascii      <= ascii_fmt;
          out_valid  <= 1'b1;
          last_value <= conv_value;
          last_valid <= 1'b1;
          pend_valid <= 1'b0;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: ;
      endcase
      if (do_load) begin
        bin_sr     <= load_value;
        bcd        <= '0;
        cnt        <= CNT_W'(WIDTH);
        conv_value <= load_value;
        state      <= SHIFT;
        busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_angle_bin2ascii.sv
// tb_angle_bin2ascii
// Directed bench for angle_bin2ascii. Two instances share one stimulus:
//   dut_a : defaults (leading blanks, SKIP_SAME=1)
//   dut_b : zero padded, SKIP_SAME=0
module tb_angle_bin2ascii;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [12:0] in_value;
  int          tests;
  int          failed;

  angle_bin2ascii_if #(.WIDTH(13), .DIGITS(4)) bus_a ();
  angle_bin2ascii_if #(.WIDTH(13), .DIGITS(4)) bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_value = in_value;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_value = in_value;

  angle_bin2ascii #(.WIDTH(13), .DIGITS(4), .BLANK_LEADING(1), .BLANK_CHAR(8'h20), .SKIP_SAME(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  angle_bin2ascii #(.WIDTH(13), .DIGITS(4), .BLANK_LEADING(0), .BLANK_CHAR(8'h20), .SKIP_SAME(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One-cycle strobe; returns 1 time unit after the accepting edge.
  task automatic strobe(input logic [12:0] v);
    in_valid = 1'b1;
    in_value = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_conv(input logic [12:0] v, input logic [31:0] exp_a,
                          input logic [31:0] exp_b, input string tag);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    strobe(v);
    while (!bus_a.out_valid && n < 40) begin
      if (bus_a.busy) busy_cnt++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 14);
    check({tag, "_busy_cycles"}, busy_cnt, 14);
    check({tag, "_busy_after"}, {31'd0, bus_a.busy}, 0);
    check({tag, "_ascii_a"}, bus_a.ascii_out, exp_a);
    check({tag, "_valid_b"}, {31'd0, bus_b.out_valid}, 1);
    check({tag, "_ascii_b"}, bus_b.ascii_out, exp_b);
  endtask

  initial begin
    int first_cyc, second_cyc, pulses, busy_gap, pulses_b;
    logic [31:0] first_a, second_a, first_b, second_b;

    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    tick();
    tick();
    check("reset_ascii_a", bus_a.ascii_out, 32'h20202030);
    check("reset_ascii_b", bus_b.ascii_out, 32'h20202030);
    check("reset_busy", {31'd0, bus_a.busy}, 0);
    check("reset_valid", {31'd0, bus_a.out_valid}, 0);
    rst = 1'b0;
    tick();

    run_conv(13'd0,    32'h20202030, 32'h30303030, "zero");
    run_conv(13'd8191, 32'h38313931, 32'h38313931, "max");
    run_conv(13'd1005, 32'h31303035, 32'h31303035, "inner_zero");
    run_conv(13'd42,   32'h20203432, 32'h30303432, "forty_two");

    // 123 accepted at cycle 0, 456 at cycle 3, 789 at cycle 8: 456 is overwritten.
    strobe(13'd123);
    first_cyc = 0; second_cyc = 0; pulses = 0; busy_gap = 0; pulses_b = 0;
    first_a = '0; second_a = '0; first_b = '0; second_b = '0;
    for (int c = 1; c <= 32; c++) begin
      in_valid = (c == 3) || (c == 8);
      in_value = (c == 3) ? 13'd456 : 13'd789;
      tick();
      if (c < 28 && !bus_a.busy) busy_gap++;
      if (bus_b.out_valid) pulses_b++;
      if (bus_a.out_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_cyc = c; first_a = bus_a.ascii_out; first_b = bus_b.ascii_out;
        end else begin
          second_cyc = c; second_a = bus_a.ascii_out; second_b = bus_b.ascii_out;
        end
      end
    end
    in_valid = 1'b0;
    check("pend_pulses", pulses, 2);
    check("pend_first_cycle", first_cyc, 14);
    check("pend_first_ascii", first_a, 32'h20313233);
    check("pend_first_ascii_b", first_b, 32'h30313233);
    check("pend_second_cycle", second_cyc, 28);
    check("pend_second_ascii", second_a, 32'h20373839);
    check("pend_second_ascii_b", second_b, 32'h30373839);
    check("pend_busy_gap", busy_gap, 0);
    check("pend_pulses_b", pulses_b, 2);
    check("pend_idle_after", {31'd0, bus_a.busy}, 0);

    // Repeat of the last value is dropped by dut_a only.
    run_conv(13'd300, 32'h20333030, 32'h30333030, "three_hundred");
    strobe(13'd300);
    check("skip_busy", {31'd0, bus_a.busy}, 0);
    check("noskip_busy_b", {31'd0, bus_b.busy}, 1);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_a.out_valid) pulses++;
      tick();
    end
    check("skip_no_valid", pulses, 0);
    run_conv(13'd301, 32'h20333031, 32'h30333031, "three_oh_one");

    // Reset at cycle 7 of a 999 conversion with 7 pending.
    strobe(13'd999);
    for (int c = 1; c <= 7; c++) begin
      in_valid = (c == 3);
      in_value = 13'd7;
      tick();
    end
    in_valid = 1'b0;
    check("abort_busy_before", {31'd0, bus_a.busy}, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus_a.busy}, 0);
    check("abort_valid", {31'd0, bus_a.out_valid}, 0);
    check("abort_ascii_a", bus_a.ascii_out, 32'h20202030);
    check("abort_ascii_b", bus_b.ascii_out, 32'h20202030);
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_a.out_valid || bus_b.out_valid || bus_a.busy) pulses++;
    end
    check("abort_quiet", pulses, 0);
    run_conv(13'd5, 32'h20202035, 32'h30303035, "five");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
